spi_xfer_ctrl: RTL and testbench

Transaction sequencer that sits directly upstream of the SPI master/slave core pair and drives its load/start/read controls.
- Accepts one command (master byte + slave byte) on a valid/ready port.
- Loads both shift registers, starts the transfer, waits a fixed bit-time budget, then reads back both received bytes.
- Returns the received bytes on a valid/ready response port, so higher-level logic never touches raw SPI core strobes.

---
 rtl/spi_xfer_ctrl.sv | 148 ++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// Command/response sequencer for the SPI master/slave core pair: loads both
// shift registers, starts the exchange, waits out the bit time, returns both bytes.
module spi_xfer_ctrl #(
  parameter int XFER_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_master_byte,
  input  logic [7:0]       cmd_slave_byte,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_master_byte,
  output logic [7:0]       rsp_slave_byte,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_count,
  output logic             load_master,
  output logic             load_slave,
  output logic             start,
  output logic             read_master,
  output logic             read_slave,
  output logic [7:0]       data_in_master,
  output logic [7:0]       data_in_slave,
  input  logic [7:0]       data_out_master,
  input  logic [7:0]       data_out_slave
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT, READ, CAP, RESP
  } state_e;

  localparam logic [7:0]       WAIT_INIT = 8'(XFER_CYCLES - 1);
  localparam logic [7:0]       WAIT_ONE  = 8'd1;
  localparam logic [CNT_W-1:0] CNT_ONE   = 1;

  state_e           state_q, state_d;
  logic [7:0]       waitCnt_q, waitCnt_d;
  logic [7:0]       dataInM_q, dataInM_d;
  logic [7:0]       dataInS_q, dataInS_d;
  logic [7:0]       rspM_q, rspM_d;
  logic [7:0]       rspS_q, rspS_d;
  logic [CNT_W-1:0] xferCnt_q, xferCnt_d;
  logic             cmdReady_q, cmdReady_d;
  logic             rspValid_q, rspValid_d;
  logic             busy_q, busy_d;
  logic             load_q, load_d;
  logic             start_q, start_d;
  logic             read_q, read_d;

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    dataInM_d = dataInM_q;
    dataInS_d = dataInS_q;
    rspM_d    = rspM_q;
    rspS_d    = rspS_q;
    xferCnt_d = xferCnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmdReady_q) begin
          dataInM_d = cmd_master_byte;
          dataInS_d = cmd_slave_byte;
          state_d   = LOAD;
        end
      end
      LOAD:  state_d = START;
      START: begin
        waitCnt_d = WAIT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        if (waitCnt_q == 8'd0) state_d = READ;
        else                   waitCnt_d = waitCnt_q - WAIT_ONE;
      end
      READ:  state_d = CAP;
      CAP: begin
        rspM_d  = data_out_master;
        rspS_d  = data_out_slave;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          xferCnt_d = xferCnt_q + CNT_ONE;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    cmdReady_d = (state_d == IDLE);
    rspValid_d = (state_d == RESP);
    busy_d     = (state_d != IDLE);
    load_d     = (state_d == LOAD);
    start_d    = (state_d == START);
    read_d     = (state_d == READ);
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      dataInM_q  <= '0;
      dataInS_q  <= '0;
      rspM_q     <= '0;
      rspS_q     <= '0;
      xferCnt_q  <= '0;
      cmdReady_q <= 1'b1;
      rspValid_q <= 1'b0;
      busy_q     <= 1'b0;
      load_q     <= 1'b0;
      start_q    <= 1'b0;
      read_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      dataInM_q  <= dataInM_d;
      dataInS_q  <= dataInS_d;
      rspM_q     <= rspM_d;
      rspS_q     <= rspS_d;
      xferCnt_q  <= xferCnt_d;
      cmdReady_q <= cmdReady_d;
      rspValid_q <= rspValid_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      start_q    <= start_d;
      read_q     <= read_d;
    end
  end

  assign cmd_ready       = cmdReady_q;
  assign rsp_valid       = rspValid_q;
  assign rsp_master_byte = rspM_q;
  assign rsp_slave_byte  = rspS_q;
  assign busy            = busy_q;
  assign xfer_count      = xferCnt_q;
  assign load_master     = load_q;
  assign load_slave      = load_q;
  assign start           = start_q;
  assign read_master     = read_q;
  assign read_slave      = read_q;
  assign data_in_master  = dataInM_q;
  assign data_in_slave   = dataInS_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: default build plus an XFER_CYCLES=1 / CNT_W=4 build,
// each wired to a loopback SPI core model that swaps the two bytes.
module tb_spi_xfer_ctrl;

  typedef struct {
    logic [7:0] m;
    logic [7:0] s;
  } rsp_t;

  typedef struct {
    logic [7:0] m;
    logic [7:0] s;
    logic [7:0] em;
    logic [7:0] es;
  } vec_t;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  always @(posedge mclk) cycleCnt <= cycleCnt + 1;

  // Build A: default parameters
  logic        reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
  logic [7:0]  cmdM, cmdS, rspM, rspS, dinM, dinS;
  logic [7:0]  doutM = 8'h00, doutS = 8'h00, coreM = 8'h00, coreS = 8'h00;
  logic [15:0] xcnt;
  logic        loadM, loadS, startA, readM, readS;

  spi_xfer_ctrl dutA (
    .mclk(mclk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_master_byte(cmdM), .cmd_slave_byte(cmdS), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_master_byte(rspM), .rsp_slave_byte(rspS),
    .busy(busy), .xfer_count(xcnt), .load_master(loadM), .load_slave(loadS),
    .start(startA), .read_master(readM), .read_slave(readS),
    .data_in_master(dinM), .data_in_slave(dinS),
    .data_out_master(doutM), .data_out_slave(doutS)
  );

  // Build B: one-cycle wait, 4-bit counter
  logic        breset, bcmd_valid, bcmd_ready, brsp_valid, brsp_ready, bbusy;
  logic [7:0]  bcmdM, bcmdS, brspM, brspS, bdinM, bdinS;
  logic [7:0]  bdoutM = 8'h00, bdoutS = 8'h00, bcoreM = 8'h00, bcoreS = 8'h00;
  logic [3:0]  bxcnt;
  logic        bloadM, bloadS, bstart, breadM, breadS;

  spi_xfer_ctrl #(.XFER_CYCLES(1), .CNT_W(4)) dutB (
    .mclk(mclk), .reset(breset), .cmd_valid(bcmd_valid), .cmd_ready(bcmd_ready),
    .cmd_master_byte(bcmdM), .cmd_slave_byte(bcmdS), .rsp_valid(brsp_valid),
    .rsp_ready(brsp_ready), .rsp_master_byte(brspM), .rsp_slave_byte(brspS),
    .busy(bbusy), .xfer_count(bxcnt), .load_master(bloadM), .load_slave(bloadS),
    .start(bstart), .read_master(breadM), .read_slave(breadS),
    .data_in_master(bdinM), .data_in_slave(bdinS),
    .data_out_master(bdoutM), .data_out_slave(bdoutS)
  );

  // Core models: output bytes are poisoned at start and only become valid on read.
  always @(posedge mclk) begin
    if (loadM) coreM <= dinM;
    if (loadS) coreS <= dinS;
    if (startA) begin doutM <= ~coreS; doutS <= ~coreM; end
    if (readM) doutM <= coreS;
    if (readS) doutS <= coreM;
  end

  always @(posedge mclk) begin
    if (bloadM) bcoreM <= bdinM;
    if (bloadS) bcoreS <= bdinS;
    if (bstart) begin bdoutM <= ~bcoreS; bdoutS <= ~bcoreM; end
    if (breadM) bdoutM <= bcoreS;
    if (breadS) bdoutS <= bcoreM;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  rsp_t expQ[$];
  rsp_t bexpQ[$];
  rsp_t popA, popB;
  int   rspSeen = 0;
  int   loadHi = 0, startHi = 0, readHi = 0;
  int   oneHotErr = 0, bOneHotErr = 0;

  // Scoreboards: compare when a handshake is about to be taken on the next edge.
  always @(negedge mclk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      rspSeen++;
      if (expQ.size() == 0) checkOutput("A unexpected response", 32'd1, 32'd0);
      else begin
        popA = expQ.pop_front();
        checkOutput("A rsp_master_byte", {24'd0, rspM}, {24'd0, popA.m});
        checkOutput("A rsp_slave_byte", {24'd0, rspS}, {24'd0, popA.s});
      end
    end
    if (!breset && brsp_valid && brsp_ready) begin
      if (bexpQ.size() == 0) checkOutput("B unexpected response", 32'd1, 32'd0);
      else begin
        popB = bexpQ.pop_front();
        checkOutput("B rsp_master_byte", {24'd0, brspM}, {24'd0, popB.m});
        checkOutput("B rsp_slave_byte", {24'd0, brspS}, {24'd0, popB.s});
      end
    end
  end

  // Strobe bookkeeping: legal patterns are none, load pair, start alone, read pair.
  always @(negedge mclk) begin
    if (loadM) loadHi++;
    if (startA) startHi++;
    if (readM) readHi++;
    if (!({loadM, loadS, startA, readM, readS} inside {5'b00000, 5'b11000, 5'b00100, 5'b00011}))
      oneHotErr++;
    if (!({bloadM, bloadS, bstart, breadM, breadS} inside {5'b00000, 5'b11000, 5'b00100, 5'b00011}))
      bOneHotErr++;
  end

  task automatic applyStimulus(input logic [7:0] m, input logic [7:0] s,
                               input logic [7:0] em, input logic [7:0] es);
    rsp_t e;
    bit   ok;
    e.m = em; e.s = es;
    expQ.push_back(e);
    cmdM = m; cmdS = s; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge mclk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) checkOutput("A accept timeout", 32'd0, 32'd1);
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [7:0] m, input logic [7:0] s,
                                input logic [7:0] em, input logic [7:0] es);
    rsp_t e;
    bit   ok;
    e.m = em; e.s = es;
    bexpQ.push_back(e);
    bcmdM = m; bcmdS = s; bcmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge mclk);
      if (bcmd_ready) ok = 1'b1;
    end
    if (!ok) checkOutput("B accept timeout", 32'd0, 32'd1);
    @(posedge mclk); #1;
    bcmd_valid = 1'b0;
  endtask

  task automatic drainA();
    for (int i = 0; i < 400; i++) begin
      @(negedge mclk);
      if (!busy && expQ.size() == 0) break;
    end
    checkOutput("A responses outstanding", expQ.size(), 32'd0);
    @(posedge mclk); #1;
  endtask

  task automatic drainB();
    for (int i = 0; i < 100; i++) begin
      @(negedge mclk);
      if (!bbusy && bexpQ.size() == 0) break;
    end
    checkOutput("B responses outstanding", bexpQ.size(), 32'd0);
    @(posedge mclk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    rsp_t e;
    int   loadC, startC, readC, rspC;
    int   l0, s0, r0, rs0;
    int   acc[4];
    bit   ok;

    vecs[0] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[2] = '{8'h55, 8'hAA, 8'hAA, 8'h55};
    vecs[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[4] = '{8'h12, 8'h34, 8'h34, 8'h12};

    reset = 1'b1; breset = 1'b1;
    cmd_valid = 1'b0; cmdM = 8'h00; cmdS = 8'h00; rsp_ready = 1'b1;
    bcmd_valid = 1'b0; bcmdM = 8'h00; bcmdS = 8'h00; brsp_ready = 1'b1;
    repeat (3) @(posedge mclk);
    #1 reset = 1'b0; breset = 1'b0;

    @(negedge mclk);
    checkOutput("reset cmd_ready", cmd_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset rsp_valid", rsp_valid, 0);
    checkOutput("reset xfer_count", xcnt, 0);
    checkOutput("reset strobes", {loadM, loadS, startA, readM, readS}, 0);
    checkOutput("reset data_in", {dinM, dinS}, 0);
    checkOutput("B reset cmd_ready", bcmd_ready, 1);
    @(posedge mclk); #1;

    // Latency: accept edge is edge 0; sample at the negedge of each following cycle.
    e.m = 8'h3C; e.s = 8'hA5;
    expQ.push_back(e);
    cmdM = 8'hA5; cmdS = 8'h3C; cmd_valid = 1'b1;
    @(posedge mclk); #1 cmd_valid = 1'b0;
    loadC = 0; startC = 0; readC = 0; rspC = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge mclk);
      if (loadM && loadC == 0) loadC = c;
      if (startA && startC == 0) startC = c;
      if (readM && readC == 0) readC = c;
      if (rsp_valid && rspC == 0) rspC = c;
    end
    checkOutput("load cycle", loadC, 1);
    checkOutput("start cycle", startC, 2);
    checkOutput("read cycle", readC, 19);
    checkOutput("rsp_valid cycle", rspC, 21);
    checkOutput("xfer_count after first", xcnt, 1);
    checkOutput("data_in held", {dinM, dinS}, 16'hA53C);
    @(posedge mclk); #1;

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i].m, vecs[i].s, vecs[i].em, vecs[i].es);
    drainA();
    checkOutput("xfer_count after table", xcnt, 6);
    checkOutput("data_in held after table", {dinM, dinS}, 16'h1234);

    // Backpressure
    rsp_ready = 1'b0;
    applyStimulus(8'h5A, 8'hC3, 8'hC3, 8'h5A);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge mclk);
      if (rsp_valid) ok = 1'b1;
    end
    checkOutput("bp rsp_valid seen", ok, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge mclk);
      checkOutput("bp rsp_valid held", rsp_valid, 1);
      checkOutput("bp bytes stable", {rspM, rspS}, 16'hC35A);
      checkOutput("bp cmd_ready low", cmd_ready, 0);
    end
    @(posedge mclk); #1 rsp_ready = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    checkOutput("post-handshake cmd_ready", cmd_ready, 1);
    checkOutput("post-handshake rsp_valid", rsp_valid, 0);
    checkOutput("xfer_count after bp", xcnt, 7);
    @(posedge mclk); #1;

    // Back-to-back with cmd_valid held high
    l0 = loadHi; s0 = startHi; r0 = readHi;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmdM = 8'h10 + 8'(i); cmdS = 8'h80 + 8'(i);
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge mclk);
        if (cmd_ready) ok = 1'b1;
      end
      if (!ok) checkOutput("b2b accept timeout", 32'd0, 32'd1);
      e.m = cmdS; e.s = cmdM;
      expQ.push_back(e);
      acc[i] = cycleCnt;
      @(posedge mclk); #1;
    end
    cmd_valid = 1'b0;
    drainA();
    for (int i = 1; i < 4; i++) checkOutput("b2b accept spacing", acc[i] - acc[i-1], 22);
    checkOutput("b2b load cycles", loadHi - l0, 4);
    checkOutput("b2b start cycles", startHi - s0, 4);
    checkOutput("b2b read cycles", readHi - r0, 4);
    checkOutput("xfer_count after b2b", xcnt, 11);

    // Reset sampled at edge 10, inside WAIT
    cmdM = 8'h11; cmdS = 8'h22; cmd_valid = 1'b1;
    @(posedge mclk); #1 cmd_valid = 1'b0;
    repeat (9) @(posedge mclk);
    #1 reset = 1'b1;
    @(posedge mclk); #1 reset = 1'b0;
    @(negedge mclk);
    checkOutput("abort strobes", {loadM, loadS, startA, readM, readS}, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort cmd_ready", cmd_ready, 1);
    checkOutput("abort rsp_valid", rsp_valid, 0);
    checkOutput("abort xfer_count", xcnt, 0);
    r0 = readHi; rs0 = rspSeen;
    repeat (30) @(negedge mclk);
    checkOutput("abort no read", readHi - r0, 0);
    checkOutput("abort no response", rspSeen - rs0, 0);
    checkOutput("abort still idle", busy, 0);

    // Build B latency with XFER_CYCLES = 1
    @(posedge mclk); #1;
    e.m = 8'h00; e.s = 8'hFF;
    bexpQ.push_back(e);
    bcmdM = 8'hFF; bcmdS = 8'h00; bcmd_valid = 1'b1;
    @(posedge mclk); #1 bcmd_valid = 1'b0;
    loadC = 0; startC = 0; readC = 0; rspC = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge mclk);
      if (bloadM && loadC == 0) loadC = c;
      if (bstart && startC == 0) startC = c;
      if (breadM && readC == 0) readC = c;
      if (brsp_valid && rspC == 0) rspC = c;
    end
    checkOutput("B load cycle", loadC, 1);
    checkOutput("B start cycle", startC, 2);
    checkOutput("B read cycle", readC, 4);
    checkOutput("B rsp_valid cycle", rspC, 6);
    checkOutput("B xfer_count after first", bxcnt, 1);
    @(posedge mclk); #1;

    // 16 more transfers on the 4-bit counter
    for (int i = 1; i <= 16; i++) begin
      applyStimulusB(8'(i * 7), 8'(i * 13), 8'(i * 13), 8'(i * 7));
      drainB();
      if (i == 15) checkOutput("B xfer_count at 16", bxcnt, 0);
    end
    checkOutput("B xfer_count wrap", bxcnt, 1);

    checkOutput("A strobe one-hot violations", oneHotErr, 0);
    checkOutput("B strobe one-hot violations", bOneHotErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
